// File: rtl/tblink_rpc_invoke_mux.sv
// tblink_rpc_invoke_mux
//   Multi-channel front end for TBLink RPC invocations. N_CHAN invoke channels are
//   round-robin arbitrated into one registered request stream toward the host bridge.
//   Blocking calls are counted per channel (at most MAX_OUTSTAND in flight). Tagged
//   bridge responses are steered into a one-entry response slot per channel.
//
//   Optional feature: define TBLINK_RPC_INVOKE_MUX_TIMEOUT_EN to give each channel a
//   watchdog. When it is enabled, a blocking call that is still unanswered after
//   TIMEOUT_CYCLES completes with an error response (rsp_err=1, rsp_data=0). When it is
//   not defined, rsp_err is constant 0 and blocking calls wait indefinitely.
//
// Ports
//   clock, reset                    rising-edge clock, asynchronous active-high reset
//   req_valid/ready/blocking        per-channel invoke handshake and blocking flag
//   req_method, req_params          per-channel payload, channel c at [c*W +: W]
//   out_valid/ready                 registered request toward the bridge
//   out_chan/blocking/method/params forwarded request fields and channel tag
//   rsp_in_valid/ready/chan/data    tagged response from the bridge
//   rsp_valid/ready/err/data        per-channel response slot
//   err_unexp                       sticky flag: response had no matching call

module tblink_rpc_invoke_mux_chan #(
    parameter int RSP_W          = 64,
    parameter int MAX_OUTSTAND   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,          // blocking call from this channel granted
    input  logic             rsp_hit,      // accepted bridge response tagged for this channel
    input  logic [RSP_W-1:0] rsp_in_data,
    input  logic             rsp_ready,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [RSP_W-1:0] rsp_data,
    output logic             at_max,
    output logic             slot_free,
    output logic             unexp
);
    localparam int OW = $clog2(MAX_OUTSTAND + 1);

    logic [OW-1:0] outstand;
    logic          live, load_rsp, tmo_fire, dec;

    assign live      = (outstand != '0);
    assign at_max    = (outstand == OW'(MAX_OUTSTAND));
    // A slot that drains this cycle can take a new response in the same cycle.
    assign slot_free = !rsp_valid || rsp_ready;
    assign unexp     = rsp_hit && !live;
    assign load_rsp  = rsp_hit && live;
    assign dec       = load_rsp || tmo_fire;

`ifdef TBLINK_RPC_INVOKE_MUX_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_cnt;

    // The counter saturates one short of the limit; firing happens on the edge that
    // would reach the limit, and stalls there while the slot is occupied or a bridge
    // response is being taken this cycle.
    assign tmo_fire = live && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) && slot_free && !rsp_hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            tmo_cnt <= '0;
        else if (!live || rsp_hit || tmo_fire)
            tmo_cnt <= '0;
        else if (tmo_cnt != TW'(TIMEOUT_CYCLES - 1))
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_fire = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            outstand <= '0;
        else if (inc && !dec)
            outstand <= outstand + 1'b1;
        else if (dec && !inc)
            outstand <= outstand - 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else if (load_rsp) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= rsp_in_data;
        end else if (tmo_fire) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end
    end
endmodule

module tblink_rpc_invoke_mux #(
    parameter int N_CHAN         = 4,
    parameter int METHOD_W       = 8,
    parameter int PARAM_W        = 64,
    parameter int RSP_W          = 64,
    parameter int MAX_OUTSTAND   = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int CW            = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_CHAN-1:0]          req_valid,
    output logic [N_CHAN-1:0]          req_ready,
    input  logic [N_CHAN-1:0]          req_blocking,
    input  logic [N_CHAN*METHOD_W-1:0] req_method,
    input  logic [N_CHAN*PARAM_W-1:0]  req_params,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CW-1:0]              out_chan,
    output logic                       out_blocking,
    output logic [METHOD_W-1:0]        out_method,
    output logic [PARAM_W-1:0]         out_params,
    input  logic                       rsp_in_valid,
    output logic                       rsp_in_ready,
    input  logic [CW-1:0]              rsp_in_chan,
    input  logic [RSP_W-1:0]           rsp_in_data,
    output logic [N_CHAN-1:0]          rsp_valid,
    input  logic [N_CHAN-1:0]          rsp_ready,
    output logic [N_CHAN-1:0]          rsp_err,
    output logic [N_CHAN*RSP_W-1:0]    rsp_data,
    output logic                       err_unexp
);
    logic [N_CHAN-1:0] elig, at_max, slot_free, unexp, rsp_hit, grant_blk;
    logic [CW-1:0]     ptr, gnt_idx;
    logic              gnt_any, load, rsp_chan_ok;

    // Nothing is accepted while reset is held, so no requester sees a spurious ready.
    assign load = !reset && (!out_valid || out_ready);
    assign elig = req_valid & ~(req_blocking & at_max);

    // Round robin: scan downward so the eligible channel closest to ptr wins.
    always_comb begin
        int k;
        k       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = N_CHAN - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= N_CHAN) k = k - N_CHAN;
            if (elig[k]) begin
                gnt_any = 1'b1;
                gnt_idx = CW'(k);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (load && gnt_any) req_ready[gnt_idx] = 1'b1;
    end
    assign grant_blk = req_ready & req_blocking;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_chan     <= '0;
            out_blocking <= 1'b0;
            out_method   <= '0;
            out_params   <= '0;
            ptr          <= '0;
        end else if (load) begin
            out_valid <= gnt_any;
            if (gnt_any) begin
                out_chan     <= gnt_idx;
                out_blocking <= req_blocking[gnt_idx];
                out_method   <= req_method[gnt_idx*METHOD_W +: METHOD_W];
                out_params   <= req_params[gnt_idx*PARAM_W +: PARAM_W];
                ptr          <= (gnt_idx == CW'(N_CHAN - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // Tags outside the channel range are always taken and then dropped.
    assign rsp_chan_ok  = ({1'b0, rsp_in_chan} < (CW + 1)'(N_CHAN));
    assign rsp_in_ready = !rsp_chan_ok || slot_free[rsp_in_chan];

    for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
        assign rsp_hit[c] = rsp_in_valid && rsp_in_ready && rsp_chan_ok && (rsp_in_chan == CW'(c));

        tblink_rpc_invoke_mux_chan #(
            .RSP_W(RSP_W), .MAX_OUTSTAND(MAX_OUTSTAND), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_chan (
            .clock(clock), .reset(reset), .inc(grant_blk[c]), .rsp_hit(rsp_hit[c]),
            .rsp_in_data(rsp_in_data), .rsp_ready(rsp_ready[c]), .rsp_valid(rsp_valid[c]),
            .rsp_err(rsp_err[c]), .rsp_data(rsp_data[c*RSP_W +: RSP_W]), .at_max(at_max[c]),
            .slot_free(slot_free[c]), .unexp(unexp[c])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            err_unexp <= 1'b0;
        else if ((rsp_in_valid && rsp_in_ready && !rsp_chan_ok) || (|unexp))
            err_unexp <= 1'b1;
    end
endmodule

// File: tb/tb_tblink_rpc_invoke_mux.sv
module tb_tblink_rpc_invoke_mux;
    localparam int N = 4, MW = 8, PW = 64, RW = 64, MAXO = 2, TMO = 16;

    logic            clock = 1'b0, reset = 1'b1;
    logic [N-1:0]    req_valid = '0, req_ready, req_blocking = '0;
    logic [N*MW-1:0] req_method = '0;
    logic [N*PW-1:0] req_params = '0;
    logic            out_valid, out_ready = 1'b1, out_blocking;
    logic [1:0]      out_chan;
    logic [MW-1:0]   out_method;
    logic [PW-1:0]   out_params;
    logic            rsp_in_valid = 1'b0, rsp_in_ready;
    logic [1:0]      rsp_in_chan = '0;
    logic [RW-1:0]   rsp_in_data = '0;
    logic [N-1:0]    rsp_valid, rsp_ready = '0, rsp_err;
    logic [N*RW-1:0] rsp_data;
    logic            err_unexp;

    always #5 clock = ~clock;

    tblink_rpc_invoke_mux #(
        .N_CHAN(N), .METHOD_W(MW), .PARAM_W(PW), .RSP_W(RW), .MAX_OUTSTAND(MAXO), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_blocking(req_blocking), .req_method(req_method), .req_params(req_params),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan), .out_blocking(out_blocking),
        .out_method(out_method), .out_params(out_params), .rsp_in_valid(rsp_in_valid),
        .rsp_in_ready(rsp_in_ready), .rsp_in_chan(rsp_in_chan), .rsp_in_data(rsp_in_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .err_unexp(err_unexp)
    );

    typedef struct packed {
        logic [1:0]    chan;
        logic          blk;
        logic [MW-1:0] method;
        logic [PW-1:0] params;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0, n_errors = 0;

    // Scoreboard: every request the bridge takes must match the oldest expected one.
    always @(negedge clock) begin
        exp_t got, want;
        if (!reset && out_valid && out_ready) begin
            got = {out_chan, out_blocking, out_method, out_params};
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL sb_extra_out: got chan=%0d method=%h, nothing expected", out_chan, out_method);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    n_errors++;
                    $display("FAIL sb_out: got chan=%0d blk=%0b method=%h params=%h, want chan=%0d blk=%0b method=%h params=%h",
                             got.chan, got.blk, got.method, got.params, want.chan, want.blk, want.method, want.params);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input int c);
        exp_t e;
        e = {2'(c), req_blocking[c], req_method[c*MW +: MW], req_params[c*PW +: PW]};
        sb.push_back(e);
    endtask

    task automatic set_payload();
        for (int c = 0; c < N; c++) begin
            req_method[c*MW +: MW] = 8'h20 + 8'(c);
            req_params[c*PW +: PW] = 64'hC0DE_0000_0000_0000 + 64'(c) * 64'h0101;
        end
    endtask

    task automatic go_idle();
        req_valid = '0; req_blocking = '0; rsp_in_valid = 1'b0; rsp_ready = '0; out_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1; go_idle(); sb.delete();
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; go_idle(); req_valid = 4'b1111;
        @(negedge clock);
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        n_checks++; if (rsp_valid !== 4'b0) begin n_errors++; $display("FAIL rst_rsp_valid: got %b want 0000", rsp_valid); end
        n_checks++; if (rsp_err !== 4'b0) begin n_errors++; $display("FAIL rst_rsp_err: got %b want 0000", rsp_err); end
        n_checks++; if (err_unexp !== 1'b0) begin n_errors++; $display("FAIL rst_err_unexp: got %0b want 0", err_unexp); end
        n_checks++; if (req_ready !== 4'b0) begin n_errors++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
        n_checks++; if ({out_method, out_params, rsp_data} !== '0) begin n_errors++; $display("FAIL rst_payload: got method=%h params=%h want 0", out_method, out_params); end
        @(posedge clock); #1;
        req_valid = '0; reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset(); set_payload();
        req_method[7:0] = 8'h12; req_valid = 4'b0001;
        @(negedge clock);
        n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        push_exp(0);
        @(posedge clock); #1; req_valid = '0;
        @(negedge clock);
        n_checks++; if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_method !== 8'h12)
            begin n_errors++; $display("FAIL single_out: got v=%0b chan=%0d method=%h want 1/0/12", out_valid, out_chan, out_method); end
        @(posedge clock); #1;
        @(negedge clock);
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL single_drop: got out_valid %0b want 0", out_valid); end
        // A non-blocking call must not consume outstanding budget: two blocking calls still fit.
        @(posedge clock); #1; req_valid = 4'b0001; req_blocking = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL single_no_outstand[%0d]: got %b want 0001", i, req_ready); end
            push_exp(0);
            @(posedge clock); #1;
        end
        go_idle();
    endtask

    task automatic test_round_robin();
        logic [3:0] gap_exp [3];
        gap_exp[0] = 4'b0010; gap_exp[1] = 4'b1000; gap_exp[2] = 4'b0010;
        do_reset(); set_payload();
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            n_checks++; if (req_ready !== 4'(1 << (i % 4))) begin n_errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i, req_ready, 4'(1 << (i % 4))); end
            push_exp(i % 4);
            @(posedge clock); #1;
        end
        req_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_checks++; if (req_ready !== gap_exp[i]) begin n_errors++; $display("FAIL rr_gap[%0d]: got %b want %b", i, req_ready, gap_exp[i]); end
            push_exp(gap_exp[i] == 4'b0010 ? 1 : 3);
            @(posedge clock); #1;
        end
        go_idle();
        @(posedge clock); #1;
        n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL rr_drained: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_outstanding_limit();
        do_reset(); set_payload();
        req_valid = 4'b0010; req_blocking = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_checks++; if (req_ready !== (i < 2 ? 4'b0010 : 4'b0000)) begin n_errors++; $display("FAIL limit_blk[%0d]: got %b want %b", i, req_ready, (i < 2 ? 4'b0010 : 4'b0000)); end
            if (i < 2) push_exp(1);
            @(posedge clock); #1;
        end
        req_blocking = 4'b0000;
        @(negedge clock);
        n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL limit_nonblk: got %b want 0010", req_ready); end
        push_exp(1);
        @(posedge clock); #1;
        req_valid = 4'b0011; req_blocking = 4'b0011;
        @(negedge clock);
        n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL limit_other_chan: got %b want 0001", req_ready); end
        push_exp(0);
        @(posedge clock); #1;
        req_valid = '0; req_blocking = '0;
    endtask

    // Runs on the state left by test_outstanding_limit: ch1 holds 2 calls, ch0 holds 1.
    task automatic test_response();
        rsp_ready = '0; rsp_in_valid = 1'b1; rsp_in_chan = 2'd1; rsp_in_data = 64'hABCD;
        #1;
        n_checks++; if (rsp_in_ready !== 1'b1) begin n_errors++; $display("FAIL rsp_accept: got %0b want 1", rsp_in_ready); end
        @(posedge clock); #1; rsp_in_valid = 1'b0;
        @(negedge clock);
        n_checks++; if (rsp_valid !== 4'b0010 || rsp_data[RW +: RW] !== 64'hABCD || rsp_err !== 4'b0)
            begin n_errors++; $display("FAIL rsp_route: got v=%b data=%h err=%b want 0010/abcd/0000", rsp_valid, rsp_data[RW +: RW], rsp_err); end
        @(posedge clock); #1;
        n_checks++; if (rsp_in_ready !== 1'b0) begin n_errors++; $display("FAIL rsp_full_ch1: got %0b want 0", rsp_in_ready); end
        rsp_in_chan = 2'd2; #1;
        n_checks++; if (rsp_in_ready !== 1'b1) begin n_errors++; $display("FAIL rsp_free_ch2: got %0b want 1", rsp_in_ready); end
        // Drain and reload the ch1 slot in the same cycle.
        rsp_in_chan = 2'd1; rsp_ready = 4'b0010; rsp_in_valid = 1'b1; rsp_in_data = 64'h5555; #1;
        n_checks++; if (rsp_in_ready !== 1'b1) begin n_errors++; $display("FAIL rsp_drain_ready: got %0b want 1", rsp_in_ready); end
        @(posedge clock); #1; rsp_in_valid = 1'b0;
        @(negedge clock);
        n_checks++; if (rsp_valid[1] !== 1'b1 || rsp_data[RW +: RW] !== 64'h5555)
            begin n_errors++; $display("FAIL rsp_reload: got v=%0b data=%h want 1/5555", rsp_valid[1], rsp_data[RW +: RW]); end
        @(posedge clock); #1;
        @(negedge clock);
        n_checks++; if (rsp_valid[1] !== 1'b0 || err_unexp !== 1'b0) begin n_errors++; $display("FAIL rsp_consumed: got v=%0b err_unexp=%0b want 0/0", rsp_valid[1], err_unexp); end
        // ch1 now has nothing outstanding. One call, then a call granted alongside a response.
        @(posedge clock); #1; set_payload(); req_valid = 4'b0010; req_blocking = 4'b0010;
        @(negedge clock);
        n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL same_cycle_pre: got %b want 0010", req_ready); end
        push_exp(1);
        @(posedge clock); #1; rsp_in_valid = 1'b1; rsp_in_data = 64'h77;
        @(negedge clock);
        n_checks++; if (req_ready !== 4'b0010 || rsp_in_ready !== 1'b1) begin n_errors++; $display("FAIL same_cycle: got ready=%b in_ready=%0b want 0010/1", req_ready, rsp_in_ready); end
        push_exp(1);
        @(posedge clock); #1; rsp_in_valid = 1'b0;
        @(negedge clock);
        n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL same_cycle_post: got %b want 0010", req_ready); end
        push_exp(1);
        @(posedge clock); #1;
        @(negedge clock);
        n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL same_cycle_limit: got %b want 0000", req_ready); end
        @(posedge clock); #1; go_idle();
    endtask

    task automatic test_unexpected();
        do_reset();
        rsp_in_valid = 1'b1; rsp_in_chan = 2'd3; rsp_in_data = 64'hDEAD; #1;
        n_checks++; if (rsp_in_ready !== 1'b1) begin n_errors++; $display("FAIL unexp_ready: got %0b want 1", rsp_in_ready); end
        @(posedge clock); #1; rsp_in_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++; if (rsp_valid !== 4'b0 || err_unexp !== 1'b1) begin n_errors++; $display("FAIL unexp_sticky: got v=%b err_unexp=%0b want 0000/1", rsp_valid, err_unexp); end
        do_reset();
        @(negedge clock);
        n_checks++; if (err_unexp !== 1'b0) begin n_errors++; $display("FAIL unexp_clear: got %0b want 0", err_unexp); end
    endtask

    task automatic test_hold_and_reset();
        do_reset(); set_payload();
        out_ready = 1'b0; req_valid = 4'b0100;
        @(negedge clock); push_exp(2);
        @(posedge clock); #1; req_valid = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_checks++; if (req_ready !== 4'b0 || out_valid !== 1'b1 || out_chan !== 2'd2 || out_method !== 8'h22)
                begin n_errors++; $display("FAIL hold[%0d]: got ready=%b v=%0b chan=%0d method=%h want 0000/1/2/22", i, req_ready, out_valid, out_chan, out_method); end
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        @(negedge clock);
        n_checks++; if (req_ready !== 4'b1000) begin n_errors++; $display("FAIL hold_release: got %b want 1000", req_ready); end
        push_exp(3);
        @(posedge clock); #1; req_valid = 4'b0010; req_blocking = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock); push_exp(1);
            @(posedge clock); #1;
        end
        // In-flight request parked on the bridge plus a buffered ch1 response, then reset.
        out_ready = 1'b0; req_valid = 4'b0001; req_blocking = 4'b0000;
        rsp_in_valid = 1'b1; rsp_in_chan = 2'd1; rsp_in_data = 64'h99;
        @(negedge clock); push_exp(0);
        @(posedge clock); #1; req_valid = '0; rsp_in_valid = 1'b0;
        @(negedge clock);
        n_checks++; if (out_valid !== 1'b1 || rsp_valid !== 4'b0010) begin n_errors++; $display("FAIL pre_reset: got v=%0b rsp_v=%b want 1/0010", out_valid, rsp_valid); end
        #2; reset = 1'b1; #1;
        n_checks++; if (out_valid !== 1'b0 || rsp_valid !== 4'b0) begin n_errors++; $display("FAIL async_reset: got v=%0b rsp_v=%b want 0/0000", out_valid, rsp_valid); end
        sb.delete();
        @(posedge clock); #1; reset = 1'b0; out_ready = 1'b1;
        req_valid = 4'b0010; req_blocking = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL post_reset_cnt[%0d]: got %b want 0010", i, req_ready); end
            push_exp(1);
            @(posedge clock); #1;
        end
        go_idle();
    endtask

`ifdef TBLINK_RPC_INVOKE_MUX_TIMEOUT_EN
    task automatic test_timeout();
        do_reset(); set_payload();
        req_valid = 4'b0100; req_blocking = 4'b0100;
        @(negedge clock);
        n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL tmo_grant: got %b want 0100", req_ready); end
        push_exp(2);
        @(posedge clock); #1; req_valid = '0;
        repeat (TMO - 1) @(posedge clock);
        @(negedge clock);
        n_checks++; if (rsp_valid[2] !== 1'b0) begin n_errors++; $display("FAIL tmo_early: got %0b want 0", rsp_valid[2]); end
        @(posedge clock);
        @(negedge clock);
        n_checks++; if (rsp_valid[2] !== 1'b1 || rsp_err[2] !== 1'b1 || rsp_data[2*RW +: RW] !== '0)
            begin n_errors++; $display("FAIL tmo_fire: got v=%0b err=%0b data=%h want 1/1/0", rsp_valid[2], rsp_err[2], rsp_data[2*RW +: RW]); end
        @(posedge clock); #1; req_valid = 4'b0100;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL tmo_outstand[%0d]: got %b want 0100", i, req_ready); end
            push_exp(2);
            @(posedge clock); #1;
        end
        go_idle();
    endtask
`else
    task automatic test_no_timeout();
        do_reset(); set_payload();
        req_valid = 4'b0100; req_blocking = 4'b0100;
        @(negedge clock); push_exp(2);
        @(posedge clock); #1; req_valid = '0;
        repeat (3 * TMO) @(posedge clock);
        @(negedge clock);
        n_checks++; if (rsp_valid !== 4'b0 || rsp_err !== 4'b0) begin n_errors++; $display("FAIL no_tmo: got v=%b err=%b want 0000/0000", rsp_valid, rsp_err); end
        go_idle();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_outstanding_limit();
        test_response();
        test_unexpected();
        test_hold_and_reset();
`ifdef TBLINK_RPC_INVOKE_MUX_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        repeat (2) @(posedge clock); #1;
        n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL sb_pending: got %0d unseen requests want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
